lmsm_mem_sequencer: RTL and testbench

Memory-side initiator for the multicycle RISC core's load-multiple (LM) and store-multiple (SM) instructions. Given a base address, direction and 8-bit register mask from the control FSM, it issues one Memory access per selected register at consecutive addresses. On SM it reads the register file; on LM it writes the register file. It drives the Memory enable/R_Wbar/address/write-data port and consumes its read data. It is the requesting end of the same port the Memory block responds on.

---
 rtl/lmsm_mem_sequencer_pkg.sv | 25 ++
 rtl/lmsm_mem_sequencer_prio_enc.sv | 28 ++
 rtl/lmsm_mem_sequencer.sv | 127 ++++++++++++
 tb/tb_lmsm_mem_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_mem_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lmsm_mem_sequencer_pkg
// Shared constants and types for the LM/SM memory sequencer:
//   ADDR_W / DATA_W / NREG  - datapath widths and register count
//   IDX_W                   - register index width (log2 NREG)
//   state_t                 - sequencer FSM state encoding
//   RW_READ / RW_WRITE      - Memory R_Wbar encodings
// -----------------------------------------------------------------------------
package lmsm_mem_sequencer_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned IDX_W  = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/lmsm_mem_sequencer_prio_enc.sv
// -----------------------------------------------------------------------------
// lmsm_prio_enc
// Combinational lowest-set-bit priority encoder for the LM/SM register mask.
// Ports:
//   i_mask  [NREG-1:0]  remaining register mask
//   o_idx   [IDX_W-1:0] index of the lowest set bit (0 when mask is empty)
//   o_valid             high when any mask bit is set
// -----------------------------------------------------------------------------
module lmsm_prio_enc
    import lmsm_mem_sequencer_pkg::*;
(
    input  logic [NREG-1:0]  i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (i_mask[i] && !o_valid) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_mem_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_mem_sequencer
// Memory-side initiator for load-multiple (LM) / store-multiple (SM).
// Issues one Memory access per selected register at consecutive addresses.
// Optional feature: define LMSM_FINAL_ADDR_EN to add Out_final_addr
// (base + popcount(mask), valid during Out_done, 0 otherwise).
// Ports:
//   clk, In_reset                 clock, synchronous active-high reset
//   In_start/In_load/In_base_addr/In_reg_mask  request from control FSM
//   Out_busy, Out_done            status (busy ACCESS..DONE, done pulse)
//   Out_Mem_Access_en/_R_Wbar/_addr, Out_Mem_Write_data, In_Mem_Read_data
//                                 Memory request port
//   Out_rf_rd_sel, In_rf_rd_data  register-file read (SM)
//   Out_rf_wr_en/_sel/_data       register-file write (LM)
//   Out_final_addr                (LMSM_FINAL_ADDR_EN only)
// -----------------------------------------------------------------------------
module lmsm_mem_sequencer
    import lmsm_mem_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              In_reset,
    input  logic              In_start,
    input  logic              In_load,
    input  logic [ADDR_W-1:0] In_base_addr,
    input  logic [NREG-1:0]   In_reg_mask,
    output logic              Out_busy,
    output logic              Out_done,
    output logic              Out_Mem_Access_en,
    output logic              Out_Mem_Access_R_Wbar,
    output logic [ADDR_W-1:0] Out_Mem_Access_addr,
    output logic [DATA_W-1:0] Out_Mem_Write_data,
    input  logic [DATA_W-1:0] In_Mem_Read_data,
    output logic [IDX_W-1:0]  Out_rf_rd_sel,
    input  logic [DATA_W-1:0] In_rf_rd_data,
    output logic              Out_rf_wr_en,
    output logic [IDX_W-1:0]  Out_rf_wr_sel,
    output logic [DATA_W-1:0] Out_rf_wr_data
`ifdef LMSM_FINAL_ADDR_EN
    ,
    output logic [ADDR_W-1:0] Out_final_addr
`endif
);

    state_t            r_state;
    logic              r_load;
    logic [NREG-1:0]   r_mask;
    logic [ADDR_W-1:0] r_count;
    logic              r_wb_pend;
    logic [IDX_W-1:0]  r_wb_sel;

    logic [IDX_W-1:0]  w_idx;
    logic              w_valid;
    logic [NREG-1:0]   w_mask_next;
    logic              w_access;
    logic              w_store;

    lmsm_prio_enc u_prio_enc (
        .i_mask  (r_mask),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_mask_next = r_mask & ~(NREG'(1) << w_idx);
    assign w_access    = (r_state == ACCESS) && w_valid;
    assign w_store     = w_access && !r_load;

    always_ff @(posedge clk) begin
        if (In_reset) begin
            r_state   <= IDLE;
            r_load    <= 1'b0;
            r_mask    <= '0;
            r_count   <= '0;
            r_wb_pend <= 1'b0;
            r_wb_sel  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wb_pend <= 1'b0;
                    if (In_start) begin
                        r_load  <= In_load;
                        r_mask  <= In_reg_mask;
                        r_count <= In_base_addr;
                        r_state <= (In_reg_mask != '0) ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    r_mask    <= w_mask_next;
                    r_count   <= r_count + ADDR_W'(1);
                    // LM read data arrives next cycle; remember where it goes.
                    r_wb_pend <= r_load;
                    r_wb_sel  <= w_idx;
                    if (w_mask_next == '0)
                        r_state <= DONE;
                end
                DONE: begin
                    r_wb_pend <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_wb_pend <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; the data paths pass through in the
    // same cycle because the register file / Memory data are combinational.
    always_comb begin
        Out_busy              = (r_state != IDLE);
        Out_done              = (r_state == DONE);
        Out_Mem_Access_en     = w_access;
        Out_Mem_Access_R_Wbar = (w_access && !r_load) ? RW_WRITE : RW_READ;
        Out_Mem_Access_addr   = w_access ? r_count : '0;
        Out_Mem_Write_data    = w_store ? In_rf_rd_data : '0;
        Out_rf_rd_sel         = w_store ? w_idx : '0;
        Out_rf_wr_en          = r_wb_pend;
        Out_rf_wr_sel         = r_wb_pend ? r_wb_sel : '0;
        Out_rf_wr_data        = r_wb_pend ? In_Mem_Read_data : '0;
    end

`ifdef LMSM_FINAL_ADDR_EN
    // In DONE the counter has advanced once per access: base + popcount.
    assign Out_final_addr = (r_state == DONE) ? r_count : '0;
`endif

endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
module tb_lmsm_mem_sequencer;
    import lmsm_mem_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              In_reset;
    logic              In_start;
    logic              In_load;
    logic [ADDR_W-1:0] In_base_addr;
    logic [NREG-1:0]   In_reg_mask;
    logic              Out_busy;
    logic              Out_done;
    logic              Out_Mem_Access_en;
    logic              Out_Mem_Access_R_Wbar;
    logic [ADDR_W-1:0] Out_Mem_Access_addr;
    logic [DATA_W-1:0] Out_Mem_Write_data;
    logic [DATA_W-1:0] In_Mem_Read_data;
    logic [IDX_W-1:0]  Out_rf_rd_sel;
    logic [DATA_W-1:0] In_rf_rd_data;
    logic              Out_rf_wr_en;
    logic [IDX_W-1:0]  Out_rf_wr_sel;
    logic [DATA_W-1:0] Out_rf_wr_data;
`ifdef LMSM_FINAL_ADDR_EN
    logic [ADDR_W-1:0] Out_final_addr;
`endif

    always #5 clk = ~clk;

    lmsm_mem_sequencer dut (
        .clk                   (clk),
        .In_reset              (In_reset),
        .In_start              (In_start),
        .In_load               (In_load),
        .In_base_addr          (In_base_addr),
        .In_reg_mask           (In_reg_mask),
        .Out_busy              (Out_busy),
        .Out_done              (Out_done),
        .Out_Mem_Access_en     (Out_Mem_Access_en),
        .Out_Mem_Access_R_Wbar (Out_Mem_Access_R_Wbar),
        .Out_Mem_Access_addr   (Out_Mem_Access_addr),
        .Out_Mem_Write_data    (Out_Mem_Write_data),
        .In_Mem_Read_data      (In_Mem_Read_data),
        .Out_rf_rd_sel         (Out_rf_rd_sel),
        .In_rf_rd_data         (In_rf_rd_data),
        .Out_rf_wr_en          (Out_rf_wr_en),
        .Out_rf_wr_sel         (Out_rf_wr_sel),
        .Out_rf_wr_data        (Out_rf_wr_data)
`ifdef LMSM_FINAL_ADDR_EN
        ,
        .Out_final_addr        (Out_final_addr)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- environment: Memory and register file ----------------
    logic [DATA_W-1:0] mem [0:65535];
    logic [DATA_W-1:0] rf  [0:NREG-1];
    logic [DATA_W-1:0] rdata;
    logic              tb_mem_we = 1'b0;
    logic [ADDR_W-1:0] tb_mem_a  = '0;
    logic [DATA_W-1:0] tb_mem_d  = '0;
    logic              tb_rf_we  = 1'b0;
    logic [IDX_W-1:0]  tb_rf_a   = '0;
    logic [DATA_W-1:0] tb_rf_d   = '0;

    always @(posedge clk) begin
        if (tb_mem_we) mem[tb_mem_a] <= tb_mem_d;
        if (Out_Mem_Access_en) begin
            if (Out_Mem_Access_R_Wbar) rdata <= mem[Out_Mem_Access_addr];
            else                       mem[Out_Mem_Access_addr] <= Out_Mem_Write_data;
        end
        if (tb_rf_we)     rf[tb_rf_a] <= tb_rf_d;
        if (Out_rf_wr_en) rf[Out_rf_wr_sel] <= Out_rf_wr_data;
    end

    assign In_Mem_Read_data = rdata;
    assign In_rf_rd_data    = rf[Out_rf_rd_sel];

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned       cyc;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  sel;
    } exp_t;

    exp_t mem_q[$];
    exp_t rf_q[$];

    task automatic push_expected(input logic ld, input logic [ADDR_W-1:0] base,
                                 input logic [NREG-1:0] mask, input int unsigned n_acc,
                                 input int unsigned n_wr, input int unsigned t0);
        int unsigned j = 0;
        exp_t e;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < NREG; i++) begin
            if (mask[i]) begin
                a = base + ADDR_W'(j);
                if (j < n_acc) begin
                    e.cyc  = t0 + 1 + j;
                    e.rw   = ld;
                    e.addr = a;
                    e.data = ld ? '0 : rf[i];
                    e.sel  = IDX_W'(i);
                    mem_q.push_back(e);
                end
                if (ld && j < n_wr) begin
                    e.cyc  = t0 + 2 + j;
                    e.rw   = 1'b1;
                    e.addr = a;
                    e.data = mem[a];
                    e.sel  = IDX_W'(i);
                    rf_q.push_back(e);
                end
                j++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (Out_Mem_Access_en === 1'b1) begin
            if (mem_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_unexpected: access addr 0x%0h at cycle %0d, none expected",
                         Out_Mem_Access_addr, cyc);
            end else begin
                e = mem_q.pop_front();
                check("mem_cycle", cyc, e.cyc);
                check("mem_rwbar", {31'b0, Out_Mem_Access_R_Wbar}, {31'b0, e.rw});
                check("mem_addr", {16'b0, Out_Mem_Access_addr}, {16'b0, e.addr});
                check("mem_wdata", {16'b0, Out_Mem_Write_data}, {16'b0, e.data});
            end
        end
        if (Out_rf_wr_en === 1'b1) begin
            if (rf_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rf_unexpected: write R%0d at cycle %0d, none expected",
                         Out_rf_wr_sel, cyc);
            end else begin
                e = rf_q.pop_front();
                check("rf_cycle", cyc, e.cyc);
                check("rf_sel", {29'b0, Out_rf_wr_sel}, {29'b0, e.sel});
                check("rf_data", {16'b0, Out_rf_wr_data}, {16'b0, e.data});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {31'b0, Out_busy}, 0);
        check({tag, "_done"},   {31'b0, Out_done}, 0);
        check({tag, "_en"},     {31'b0, Out_Mem_Access_en}, 0);
        check({tag, "_rwbar"},  {31'b0, Out_Mem_Access_R_Wbar}, 1);
        check({tag, "_addr"},   {16'b0, Out_Mem_Access_addr}, 0);
        check({tag, "_wdata"},  {16'b0, Out_Mem_Write_data}, 0);
        check({tag, "_rdsel"},  {29'b0, Out_rf_rd_sel}, 0);
        check({tag, "_wren"},   {31'b0, Out_rf_wr_en}, 0);
        check({tag, "_wrsel"},  {29'b0, Out_rf_wr_sel}, 0);
        check({tag, "_wrdata"}, {16'b0, Out_rf_wr_data}, 0);
`ifdef LMSM_FINAL_ADDR_EN
        check({tag, "_final"},  {16'b0, Out_final_addr}, 0);
`endif
    endtask

    task automatic preload_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_mem_we = 1'b1; tb_mem_a = a; tb_mem_d = d;
        @(negedge clk);
        tb_mem_we = 1'b0;
    endtask

    task automatic preload_rf(input int unsigned r, input logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_rf_we = 1'b1; tb_rf_a = IDX_W'(r); tb_rf_d = d;
        @(negedge clk);
        tb_rf_we = 1'b0;
    endtask

    typedef struct {
        logic              load;
        logic [ADDR_W-1:0] base;
        logic [NREG-1:0]   mask;
        logic              ign;       // pulse a junk In_start in cycle 1
        int unsigned       exp_done;  // cycle of Out_done
        logic [ADDR_W-1:0] exp_final;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned t0;
        int unsigned done_at = 0;
        int unsigned k;
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'b0, Out_busy}, 0);
        check({tag, "_idle_done"}, {31'b0, Out_done}, 0);
        check({tag, "_q_empty"}, mem_q.size() + rf_q.size(), 0);
        t0 = cyc;
        k  = $countones(v.mask);
        In_start = 1'b1; In_load = v.load; In_base_addr = v.base; In_reg_mask = v.mask;
        push_expected(v.load, v.base, v.mask, k, k, t0);
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            @(negedge clk);
            if (Out_done === 1'b1) begin
                done_at = c;
                check({tag, "_busy_at_done"}, {31'b0, Out_busy}, 1);
`ifdef LMSM_FINAL_ADDR_EN
                check({tag, "_final_addr"}, {16'b0, Out_final_addr}, {16'b0, v.exp_final});
`endif
            end
            if (c == 1 && v.ign) begin
                In_start = 1'b1; In_load = ~v.load; In_base_addr = 16'hAAAA; In_reg_mask = 8'h5A;
            end else begin
                In_start = 1'b0;
            end
        end
        check({tag, "_done_cycle"}, done_at, v.exp_done);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0010, 8'b1000_0101, 1'b0, 4, 16'h0013};
        vecs[1] = '{1'b1, 16'h0000, 8'b0000_0011, 1'b0, 3, 16'h0002};
        vecs[2] = '{1'b0, 16'h0100, 8'b0000_0000, 1'b1, 1, 16'h0100};
        vecs[3] = '{1'b0, 16'hFFFF, 8'b0000_0011, 1'b1, 3, 16'h0001};
        vecs[4] = '{1'b1, 16'h0010, 8'b1111_1111, 1'b0, 9, 16'h0018};
        vecs[5] = '{1'b1, 16'hFFFE, 8'b1001_0000, 1'b0, 3, 16'h0000};
        vecs[6] = '{1'b1, 16'h0020, 8'b0000_1111, 1'b0, 5, 16'h0024};

        In_reset = 1'b1; In_start = 1'b0; In_load = 1'b0;
        In_base_addr = '0; In_reg_mask = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        In_reset = 1'b0;

        preload_rf(0, 16'd13); preload_rf(1, 16'h1111); preload_rf(2, 16'd23);
        preload_rf(3, 16'h3333); preload_rf(4, 16'h4444); preload_rf(5, 16'h5555);
        preload_rf(6, 16'h6666); preload_rf(7, 16'd53);
        preload_mem(16'h0000, 16'd13); preload_mem(16'h0001, 16'd23);
        for (int a = 16'h13; a <= 16'h17; a++) preload_mem(16'(a), 16'(16'h0B00 + a));
        preload_mem(16'hFFFE, 16'hBEEF);
        for (int a = 16'h20; a <= 16'h23; a++) preload_mem(16'(a), 16'(16'hC000 + a));

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        In_start = 1'b0;

        // Reset during an LM of 4 registers, asserted in cycle 2.
        @(negedge clk);
        push_expected(1'b1, 16'h0020, 8'b0000_1111, 2, 1, cyc);
        In_start = 1'b1; In_load = 1'b1; In_base_addr = 16'h0020; In_reg_mask = 8'b0000_1111;
        @(negedge clk);
        In_start = 1'b0;
        @(negedge clk);
        In_reset = 1'b1;
        @(negedge clk);
        In_reset = 1'b0;
        check_reset_outputs("midrst_c3");
        @(negedge clk);
        check_reset_outputs("midrst_c4");
        @(negedge clk);
        check("midrst_q_empty", mem_q.size() + rf_q.size(), 0);

        // Reset and start together: the start is lost.
        In_reset = 1'b1; In_start = 1'b1; In_load = 1'b0;
        In_base_addr = 16'h0300; In_reg_mask = 8'hFF;
        @(negedge clk);
        In_reset = 1'b0; In_start = 1'b0;
        check("rst_start_busy", {31'b0, Out_busy}, 0);
        @(negedge clk);
        check("rst_start_busy2", {31'b0, Out_busy}, 0);
        check("rst_start_en", {31'b0, Out_Mem_Access_en}, 0);

        run_vec(vecs[6], "after_rst");

        @(negedge clk);
        @(negedge clk);
        check("final_q_empty", mem_q.size() + rf_q.size(), 0);
        check_reset_outputs("end_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
